// File: rtl/multi_operand_adder_pipe.sv
//------------------------------------------------------------------------------
// Module  : multi_operand_adder_pipe
// Purpose : Pipelined N_IN-operand adder tree with valid/ready backpressure.
//           Optional running accumulator enabled by macro ADDER_ACC_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_operand_adder_pipe #(
  parameter int N_IN   = 4,
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0,
`ifdef ADDER_ACC_EN
  parameter int ACC_W  = 16,
`endif
  localparam int SUM_W = WIDTH + $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*WIDTH-1:0]  in_data,
`ifdef ADDER_ACC_EN
  input  logic                   acc_clr,
  output logic [ACC_W-1:0]       acc_sum,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       out_sum
);

  localparam int STAGES    = $clog2(N_IN);
  localparam int LEAVES    = 1 << STAGES;
  localparam int NODES_TOT = 2 * LEAVES - 1;
  localparam int EXT_W     = SUM_W - WIDTH;

  // All tree levels live in one flat vector; level k starts at node lvl_off(k).
  function automatic int lvl_off(input int k);
    return 2 * LEAVES - 2 * (LEAVES >> k);
  endfunction

  logic [NODES_TOT*SUM_W-1:0] tree_d;
  logic [NODES_TOT*SUM_W-1:0] tree_q;
  logic [NODES_TOT*SUM_W-1:0] ld_mask;
  logic [STAGES:0]            vld_d;
  logic [STAGES:0]            vld_q;
  logic [STAGES:0]            ld_lvl;
  logic                       adv;

  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = adv;
  assign vld_d    = {vld_q[STAGES-1:0], in_valid};
  // A level only captures data when a valid set moves into it, so bubbles
  // never overwrite the last result held on out_sum.
  assign ld_lvl   = {(STAGES+1){adv}} & vld_d;

  genvar gi, gk, gj;

  for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
    if (gi < N_IN) begin : g_op
      if (SIGNED != 0) begin : g_sx
        assign tree_d[gi*SUM_W +: SUM_W] =
          {{EXT_W{in_data[gi*WIDTH+WIDTH-1]}}, in_data[gi*WIDTH +: WIDTH]};
      end else begin : g_zx
        assign tree_d[gi*SUM_W +: SUM_W] =
          {{EXT_W{1'b0}}, in_data[gi*WIDTH +: WIDTH]};
      end
    end else begin : g_pad
      assign tree_d[gi*SUM_W +: SUM_W] = '0;
    end
  end

  for (gk = 1; gk <= STAGES; gk++) begin : g_level
    for (gj = 0; gj < (LEAVES >> gk); gj++) begin : g_node
      localparam int DST = lvl_off(gk) + gj;
      localparam int SRC = lvl_off(gk - 1) + 2 * gj;
      assign tree_d[DST*SUM_W +: SUM_W] =
        tree_q[SRC*SUM_W +: SUM_W] + tree_q[(SRC+1)*SUM_W +: SUM_W];
    end
  end

  for (gk = 0; gk <= STAGES; gk++) begin : g_mask
    localparam int LO = lvl_off(gk) * SUM_W;
    localparam int NB = (LEAVES >> gk) * SUM_W;
    assign ld_mask[LO +: NB] = {NB{ld_lvl[gk]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q <= '0;
      vld_q  <= '0;
    end else if (adv) begin
      tree_q <= (tree_d & ld_mask) | (tree_q & ~ld_mask);
      vld_q  <= vld_d;
    end
  end

  assign out_valid = vld_q[STAGES];
  assign out_sum   = tree_q[(NODES_TOT-1)*SUM_W +: SUM_W];

`ifdef ADDER_ACC_EN
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_ext;
  logic [ACC_W-1:0] acc_base;

  if (SIGNED != 0) begin : g_acc_sx
    assign acc_ext = ACC_W'($signed(out_sum));
  end else begin : g_acc_zx
    assign acc_ext = ACC_W'(out_sum);
  end

  // Clear takes priority over the old value but not over a same-cycle result.
  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    acc_d    = acc_base;
    if (out_valid && out_ready) begin
      acc_d = acc_base + acc_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_sum = acc_q;
`endif

endmodule

`default_nettype wire

// File: doc/multi_operand_adder_pipe.md
Name: multi_operand_adder_pipe

Overview:
Parametrised, pipelined successor to the team's combinational four-operand 4-bit summer. Sums N_IN operands of WIDTH bits, either unsigned or two's-complement, through a registered binary adder tree with one register stage per tree level. Uses a valid/ready handshake with full backpressure so it can sit between streaming producers and consumers. Overflow cannot occur because the output width grows with the operand count.

Parameters:
N_IN, 4, operand count; legal range 2..64.
WIDTH, 4, bits per operand; 1..32.
SIGNED, 0, 0 = unsigned (zero-extend), 1 = two's-complement (sign-extend).
SUM_W, WIDTH+$clog2(N_IN), derived (localparam), output width; 6 at the defaults.
STAGES, $clog2(N_IN), derived (localparam), tree depth and latency in cycles.
ACC_W, 16, accumulator width; used only when ADDER_ACC_EN is defined.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  in_data holds a valid operand set.
in_ready  out  1  block can accept an operand set this cycle.
in_data  in  N_IN*WIDTH  packed operands; operand i = in_data[i*WIDTH +: WIDTH].
out_valid  out  1  out_sum holds a valid result.
out_ready  in  1  consumer accepts the result this cycle.
out_sum  out  SUM_W  sum of one accepted operand set.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits = 0, all stage data registers = 0, out_valid = 0, out_sum = 0. Any in-flight operand sets are discarded and produce no output.
- Operand extension: each operand is extended to SUM_W bits before level 0 (zero-extend if SIGNED=0, sign-extend if SIGNED=1).
- Padding: if N_IN is not a power of two, missing tree leaves are tied to 0.
- Tree structure: level k pairwise-adds level k-1 and registers the result. There are STAGES levels; the last level's register drives out_sum directly.
- Advance enable: adv = !out_valid || out_ready. The entire pipeline, including valid bits, shifts only when adv = 1 and holds every register when adv = 0.
- Input handshake: in_ready = adv, combinational. An input transfer occurs when in_valid && in_ready. When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Latency and throughput: with out_ready held high, an operand set accepted at edge t appears on out_sum with out_valid = 1 after edge t+STAGES. Throughput is one result per cycle.
- Output stability: out_sum and out_valid hold steady while out_valid && !out_ready. No result is lost or duplicated under arbitrary out_ready patterns.
- Bubbles: when the output stage is empty, out_sum holds its last value and out_valid = 0.
- Arithmetic: results are exact and never wrap. Unsigned range is 0..N_IN*(2^WIDTH-1); signed range is N_IN*(-2^(WIDTH-1))..N_IN*(2^(WIDTH-1)-1).

Optional Feature:
Macro ADDER_ACC_EN.
- When defined, adds two ports: acc_clr (in, 1) and acc_sum (out, ACC_W).
  - acc_sum resets to 0.
  - On each output transfer (out_valid && out_ready), acc_sum += out_sum extended to ACC_W using the SIGNED rule. The accumulator wraps modulo 2^ACC_W.
  - acc_clr = 1 sets acc_sum to 0 on the next edge.
  - If acc_clr and a transfer occur in the same cycle, acc_sum = extended out_sum (clear first, then add).
- When not defined, neither port exists, no accumulator logic is synthesised, and the rest of the behaviour is identical.

Test Plan:
1. Defaults, out_ready=1, in_data operands 15,15,15,15 for one cycle -> out_sum=60 (6'b111100), out_valid high for exactly 1 cycle, 2 edges after acceptance.
2. SIGNED=1, operands -8,-8,-8,-8 then 7,7,7,7 -> out_sum 6'b100000 (-32), then 6'b011100 (28), on consecutive cycles.
3. N_IN=5, WIDTH=4, operands 1,2,3,4,5 -> out_sum=15, latency 3 cycles (SUM_W=7).
4. Stream sums 1..5 (each set e.g. {k,0,0,0}); drop out_ready for 3 cycles mid-stream -> in_ready low during the stall, out_sum held stable, output sequence exactly 1,2,3,4,5 with no loss or duplication.
5. Assert rst for 1 cycle while 2 sets are in flight -> out_valid=0 and out_sum=0 immediately; no stale result emerges afterwards; the next accepted set 3,3,3,3 yields 12.
6. With ADDER_ACC_EN defined: results 60,60,60 -> acc_sum=180. Then acc_clr together with result 10 -> acc_sum=10. With ACC_W=8, results 200 then 100 -> acc_sum=44 (wrap).
